// File: rtl/binary_clock_ctrl.sv
// Binary clock timekeeping and time-set controller: debounced buttons, 1 Hz enable, HH:MM:SS chain.
// Optional 12-hour display mapping when H12_DISPLAY_EN is defined.
//
// state      | meaning
// ST_RUN     | time advances on each 1 Hz tick
// ST_SET_HR  | time frozen, inc press steps hours
// ST_SET_MIN | time frozen, inc press steps minutes
module binary_clock_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick_1hz
);

    localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_TC   = PS_W'(CLK_HZ - 1);
    localparam logic [PS_W-1:0] PS_HALF = PS_W'(CLK_HZ / 2);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    // Button vectors: bit 0 = mode, bit 1 = inc.
    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]            stable_q, stable_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            press;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [5:0]        sec_q, sec_d;
    logic [5:0]        min_q, min_d;
    logic [4:0]        hr_q, hr_d;
    logic              tick;

    // Down-counter reloads whenever the sample agrees with the accepted level,
    // so only an unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
        sync1_d  = {btn_inc, btn_mode};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        press    = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
                db_cnt_d[b] = DB_LOAD;
            end else if (db_cnt_q[b] == '0) begin
                stable_d[b] = sync2_q[b];
                db_cnt_d[b] = DB_LOAD;
                press[b]    = sync2_q[b];
            end else begin
                db_cnt_d[b] = db_cnt_q[b] - 1'b1;
            end
        end
    end

    always_comb begin
        tick    = (ps_q == PS_TC) && (state_q == ST_RUN);
        ps_d    = (ps_q == PS_TC) ? '0 : ps_q + 1'b1;
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;

        if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    hr_d  = (hr_q == 5'd23) ? '0 : hr_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end

        // Mode press has priority over inc; seconds clear after any same-cycle tick.
        case (state_q)
            ST_RUN: begin
                if (press[0]) begin
                    state_d = ST_SET_HR;
                    sec_d   = '0;
                end
            end
            ST_SET_HR: begin
                if (press[0]) begin
                    state_d = ST_SET_MIN;
                end else if (press[1]) begin
                    hr_d = (hr_q == 5'd23) ? '0 : hr_q + 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (press[0]) begin
                    state_d = ST_RUN;
                    ps_d    = '0;
                end else if (press[1]) begin
                    min_d = (min_q == 6'd59) ? '0 : min_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            db_cnt_q <= {2{DB_LOAD}};
            state_q  <= ST_RUN;
            ps_q     <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hr_q     <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            ps_q     <= ps_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hr_q     <= hr_d;
        end
    end

    assign tick_1hz = tick;
    assign mode     = state_q;
    assign seconds  = sec_q;
    assign minutes  = min_q;
    assign blink    = (state_q != ST_RUN) && (ps_q >= PS_HALF);

`ifdef H12_DISPLAY_EN
    always_comb begin
        hours = hr_q;
        pm    = 1'b0;
        if (hr_q == 5'd0) begin
            hours = 5'd12;
        end else if (hr_q == 5'd12) begin
            pm = 1'b1;
        end else if (hr_q > 5'd12) begin
            hours = hr_q - 5'd12;
            pm    = 1'b1;
        end
    end
`else
    assign hours = hr_q;
    assign pm    = 1'b0;
`endif

endmodule

// File: doc/binary_clock_ctrl.md
Name: binary_clock_ctrl

Overview:
- Timekeeping and set-mode controller for the binary clock.
- Derives a one-cycle 1 Hz enable from the 100 MHz system clock; no divided clock.
- Runs an HH:MM:SS counter chain and sequences a button-driven time-set FSM.
- Drives the LED bit fields for hours, minutes and seconds directly.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency; prescaler terminal count is CLK_HZ-1.
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock, 100 MHz; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- btn_mode  input  1  raw mode button, active-high, asynchronous to clk_in.
- btn_inc  input  1  raw increment button, active-high, asynchronous to clk_in.
- seconds  output  6  seconds 0..59, binary.
- minutes  output  6  minutes 0..59, binary.
- hours  output  5  hours 0..23, or 1..12 with H12_DISPLAY_EN.
- pm  output  1  PM flag (H12_DISPLAY_EN only, else tied 0).
- mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN.
- blink  output  1  field-blink strobe for the field being set.
- tick_1hz  output  1  one-cycle pulse each elapsed second in RUN.

Behaviour:
- Clock and reset:
  - One clock domain (clk_in); reset is asynchronous, active-low.
  - On reset assertion, all state clears immediately: seconds=0, minutes=0, hours=0 (reads 12 AM with H12_DISPLAY_EN), pm=0, mode=RUN, blink=0, tick_1hz=0, prescaler=0, debounce state cleared.
  - Reset mid-set abandons the set and returns to RUN at 00:00:00.
- Button front end, identical per button:
  - 2-FF synchronizer, then debounce counter; the accepted level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - Rising edge of the accepted level gives a one-cycle press pulse.
  - Holding a button produces exactly one pulse; releasing produces none.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps.
  - tick_1hz=1 in the cycle the count equals CLK_HZ-1 and mode=RUN; 0 otherwise.
- Time chain, applied on tick_1hz in the same cycle (outputs update the next edge):
  - seconds 59->0 with minutes+1.
  - minutes 59->0 with hours+1.
  - hours 23->0.
  - 23:59:59 rolls to 00:00:00 in one step.
- FSM, driven by the mode press pulse: RUN -> SET_HR -> SET_MIN -> RUN.
  - Entering SET_HR: seconds cleared to 0.
  - While in SET_HR/SET_MIN: prescaler keeps running, no ticks, time is frozen.
  - Inc press in SET_HR: hours+1, 23->0, no carry.
  - Inc press in SET_MIN: minutes+1, 59->0, no carry into hours.
  - Inc press in RUN: ignored.
  - SET_MIN->RUN: prescaler cleared to 0, so the first tick comes exactly CLK_HZ cycles after the transition edge.
  - Mode and inc press pulses in the same cycle: mode wins, inc is dropped.
  - A mode press coinciding with a RUN tick: the tick applies first, then seconds clear on entry to SET_HR.
- blink:
  - In SET_HR/SET_MIN: 1 while prescaler >= CLK_HZ/2, 0 otherwise.
  - In RUN: 0.
- All outputs are registered or decoded from registers only; no combinational path from the button inputs.

Optional Feature:
- Macro: H12_DISPLAY_EN.
- Defined:
  - The internal counter stays 0..23; the hours output is mapped as 0->12 with pm=0, 1..11 with pm=0, 12->12 with pm=1, 13..23->1..11 with pm=1.
  - Set-mode increments still step the internal 0..23 counter.
- Undefined:
  - hours outputs 0..23 directly; pm is constant 0.

Test Plan (CLK_HZ=10, DEBOUNCE_CYCLES=4):
- Reset released, no buttons -> tick_1hz high for 1 cycle every 10 cycles; after 600 cycles seconds=0 and minutes=1.
- Preload 23:59:59 via set mode and 59 ticks, apply one more tick -> next edge hours=0, minutes=0, seconds=0.
- btn_mode high 3 cycles then low -> no mode change; high 10 cycles -> mode=01 exactly once, seconds=0, tick_1hz stays 0 while mode!=00.
- In SET_HR at hours=23, one inc press -> hours=0, minutes unchanged. Then mode, inc x60 -> minutes wraps back to its start value. Then mode -> mode=00, first tick exactly 10 cycles after the transition.
- Mode and inc press pulses forced in the same cycle in SET_HR -> mode=10, hours unchanged; reset_n pulled low mid-SET_MIN -> all outputs 0 immediately, mode=00.
- With H12_DISPLAY_EN: internal 0 -> hours=12, pm=0; internal 13 -> hours=1, pm=1; internal 12 -> hours=12, pm=1.
